// File: rtl/sd_fifo_head_b_pkg.sv
// Shared definitions for the memory-based srdy/drdy FIFO head and tail controllers.
// Pointer arithmetic is done on 32-bit values so one helper serves every pointer width.
package sd_fifo_head_b_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 16;

    // Advance a pointer inside the region lo..hi, wrapping from hi back to lo.
    function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned lo,
                                            input int unsigned hi);
        return (p == hi) ? lo : p + 32'd1;
    endfunction

    function automatic int unsigned fifo_size(input int unsigned lo, input int unsigned hi);
        return hi - lo + 32'd1;
    endfunction

endpackage

// File: rtl/sd_fifo_head_b_if.sv
// Consumer-side srdy/drdy handshake into the FIFO head, with optional commit/abort.
interface sd_fifo_head_b_if
    import sd_fifo_head_b_pkg::*;
#(
    parameter int unsigned width = DefWidth
) ();

    logic             c_srdy;
    logic             c_drdy;
    logic             c_commit;
    logic             c_abort;
    logic [width-1:0] c_data;

    modport master (
        output c_srdy,
        output c_commit,
        output c_abort,
        output c_data,
        input  c_drdy
    );

    modport slave (
        input  c_srdy,
        input  c_commit,
        input  c_abort,
        input  c_data,
        output c_drdy
    );

endinterface

// File: rtl/sd_fifo_head_b.sv
// Write-side controller of the big memory-based FIFO: writes accepted words into a bounded
// region of a shared memory and publishes a (optionally speculative) write pointer to the tail.
module sd_fifo_head_b
    import sd_fifo_head_b_pkg::*;
#(
    parameter int unsigned width  = DefWidth,
    parameter int unsigned depth  = DefDepth,
    parameter int unsigned commit = 0,
    parameter int unsigned asz    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [asz-1:0]   bound_low,
    input  logic [asz-1:0]   bound_high,
    sd_fifo_head_b_if.slave  c_if,
    input  logic [asz-1:0]   rdptr,
    output logic [asz-1:0]   cur_wrptr,
    output logic [asz-1:0]   com_wrptr,
    output logic             mem_we,
    output logic [asz-1:0]   mem_wr_addr,
    output logic [width-1:0] mem_wr_data,
    output logic [asz:0]     nfree
);

    localparam bit HasCommit = (commit != 0);

    logic [asz-1:0] r_cur_wrptr;
    logic [asz-1:0] w_cur_wrptr_d;
    logic [asz-1:0] w_cur_inc;
    logic [asz-1:0] w_com_wrptr;
    logic           w_full;
    logic           w_abort;
    logic           w_drdy;
    logic           w_we;
    logic [asz:0]   w_size;
    logic [asz:0]   w_cur_ext;
    logic [asz:0]   w_rd_ext;
    logic [asz:0]   w_one;
    int unsigned    w_inc32;
    int unsigned    w_size32;

    always_comb begin
        w_inc32   = ptr_inc(32'(r_cur_wrptr), 32'(bound_low), 32'(bound_high));
        w_cur_inc = w_inc32[asz-1:0];
        w_size32  = fifo_size(32'(bound_low), 32'(bound_high));
        w_size    = w_size32[asz:0];
        w_one     = {{asz{1'b0}}, 1'b1};

        w_abort = HasCommit & c_if.c_abort;
        w_full  = (w_cur_inc == rdptr);
        // Held low during reset so nothing is accepted while the pointers are being forced.
        w_drdy  = enable & ~reset & ~w_full & ~w_abort;
        w_we    = c_if.c_srdy & w_drdy;

        w_cur_wrptr_d = r_cur_wrptr;
        if (w_abort) begin
            w_cur_wrptr_d = w_com_wrptr;
        end else if (w_we) begin
            w_cur_wrptr_d = w_cur_inc;
        end

        w_cur_ext = {1'b0, r_cur_wrptr};
        w_rd_ext  = {1'b0, rdptr};
        if (w_rd_ext > w_cur_ext) begin
            nfree = w_rd_ext - w_cur_ext - w_one;
        end else begin
            nfree = w_size - (w_cur_ext - w_rd_ext) - w_one;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_wrptr <= bound_low;
        end else begin
            r_cur_wrptr <= w_cur_wrptr_d;
        end
    end

    if (HasCommit) begin : g_commit
        logic [asz-1:0] r_com_wrptr;

        // Abort wins over commit; a word written alongside c_commit is part of the commit.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_com_wrptr <= bound_low;
            end else if (c_if.c_commit && !c_if.c_abort) begin
                r_com_wrptr <= w_cur_wrptr_d;
            end
        end

        assign w_com_wrptr = r_com_wrptr;
    end else begin : g_no_commit
        logic w_unused_commit;

        assign w_unused_commit = c_if.c_commit;
        assign w_com_wrptr     = r_cur_wrptr;
    end

    assign c_if.c_drdy = w_drdy;
    assign cur_wrptr   = r_cur_wrptr;
    assign com_wrptr   = w_com_wrptr;
    assign mem_we      = w_we;
    assign mem_wr_addr = r_cur_wrptr;
    assign mem_wr_data = c_if.c_data;

endmodule

// File: tb/tb_sd_fifo_head_b.sv
// Directed bench for sd_fifo_head_b: one instance without commit, one with commit/abort.
module tb_sd_fifo_head_b;

    localparam int unsigned W   = 8;
    localparam int unsigned ASZ = 4;

    logic           clk;
    logic           reset;
    logic           enable;
    logic [ASZ-1:0] bound_low;
    logic [ASZ-1:0] bound_high;
    logic [ASZ-1:0] rdptr;

    logic [ASZ-1:0] cur0, com0, addr0, cur1, com1, addr1;
    logic           we0, we1;
    logic [W-1:0]   wdata0, wdata1;
    logic [ASZ:0]   nfree0, nfree1;

    int n_checks = 0;
    int n_pass   = 0;

    sd_fifo_head_b_if #(.width(W)) u_if0 ();
    sd_fifo_head_b_if #(.width(W)) u_if1 ();

    sd_fifo_head_b #(.width(W), .depth(16), .commit(0)) u_dut0 (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bound_low   (bound_low),
        .bound_high  (bound_high),
        .c_if        (u_if0),
        .rdptr       (rdptr),
        .cur_wrptr   (cur0),
        .com_wrptr   (com0),
        .mem_we      (we0),
        .mem_wr_addr (addr0),
        .mem_wr_data (wdata0),
        .nfree       (nfree0)
    );

    sd_fifo_head_b #(.width(W), .depth(16), .commit(1)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bound_low   (bound_low),
        .bound_high  (bound_high),
        .c_if        (u_if1),
        .rdptr       (rdptr),
        .cur_wrptr   (cur1),
        .com_wrptr   (com1),
        .mem_we      (we1),
        .mem_wr_addr (addr1),
        .mem_wr_data (wdata1),
        .nfree       (nfree1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [ASZ-1:0] wrap_addr [3];
        wrap_addr[0] = 4'd11;
        wrap_addr[1] = 4'd2;
        wrap_addr[2] = 4'd3;

        reset        = 1'b1;
        enable       = 1'b1;
        bound_low    = 4'd2;
        bound_high   = 4'd11;
        rdptr        = 4'd2;
        u_if0.c_srdy = 1'b0; u_if0.c_commit = 1'b0; u_if0.c_abort = 1'b0; u_if0.c_data = '0;
        u_if1.c_srdy = 1'b0; u_if1.c_commit = 1'b0; u_if1.c_abort = 1'b0; u_if1.c_data = '0;

        // Reset state
        #3;
        check_eq("rst_cur0", 32'(cur0), 32'd2);
        check_eq("rst_com0", 32'(com0), 32'd2);
        check_eq("rst_we0", 32'(we0), 32'd0);
        check_eq("rst_drdy0", 32'(u_if0.c_drdy), 32'd0);
        check_eq("rst_cur1", 32'(cur1), 32'd2);
        check_eq("rst_com1", 32'(com1), 32'd2);
        tick();
        reset = 1'b0;
        #3;
        check_eq("idle_nfree0", 32'(nfree0), 32'd9);
        check_eq("idle_drdy0", 32'(u_if0.c_drdy), 32'd1);
        check_eq("idle_we0", 32'(we0), 32'd0);

        // Grant low blocks writes even with data offered
        enable       = 1'b0;
        u_if0.c_srdy = 1'b1;
        #1;
        check_eq("noen_drdy0", 32'(u_if0.c_drdy), 32'd0);
        check_eq("noen_we0", 32'(we0), 32'd0);
        enable = 1'b1;

        // Fill 9 words
        for (int i = 0; i < 9; i++) begin
            u_if0.c_data = 8'hA0 + 8'(i);
            #1;
            check_eq($sformatf("fill_we%0d", i), 32'(we0), 32'd1);
            check_eq($sformatf("fill_addr%0d", i), 32'(addr0), 32'(2 + i));
            check_eq($sformatf("fill_data%0d", i), 32'(wdata0), 32'(8'hA0 + 8'(i)));
            tick();
        end
        #1;
        check_eq("full_cur0", 32'(cur0), 32'd11);
        check_eq("full_drdy0", 32'(u_if0.c_drdy), 32'd0);
        check_eq("full_nfree0", 32'(nfree0), 32'd0);
        check_eq("full_we0", 32'(we0), 32'd0);

        // Tail frees 3 entries; write across the wrap point
        rdptr = 4'd5;
        #1;
        check_eq("wrap_nfree0", 32'(nfree0), 32'd3);
        check_eq("wrap_drdy0", 32'(u_if0.c_drdy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            u_if0.c_data = 8'hB0 + 8'(i);
            #1;
            check_eq($sformatf("wrap_addr%0d", i), 32'(addr0), 32'(wrap_addr[i]));
            check_eq($sformatf("wrap_we%0d", i), 32'(we0), 32'd1);
            tick();
        end
        #1;
        check_eq("wrap_cur0", 32'(cur0), 32'd4);
        check_eq("wrap_com0", 32'(com0), 32'd4);
        check_eq("wrap_full_drdy0", 32'(u_if0.c_drdy), 32'd0);
        check_eq("wrap_full_nfree0", 32'(nfree0), 32'd0);
        u_if0.c_srdy = 1'b0;

        // Commit instance: 4 speculative words, then a two-cycle abort
        rdptr        = 4'd2;
        u_if1.c_srdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u_if1.c_data = 8'hC0 + 8'(i);
            #1;
            check_eq($sformatf("spec_addr%0d", i), 32'(addr1), 32'(2 + i));
            tick();
        end
        check_eq("spec_cur1", 32'(cur1), 32'd6);
        check_eq("spec_com1", 32'(com1), 32'd2);
        u_if1.c_abort = 1'b1;
        #1;
        check_eq("abort_drdy1", 32'(u_if1.c_drdy), 32'd0);
        check_eq("abort_we1", 32'(we1), 32'd0);
        tick();
        check_eq("abort_cur1", 32'(cur1), 32'd2);
        check_eq("abort_com1", 32'(com1), 32'd2);
        tick();
        check_eq("abort2_cur1", 32'(cur1), 32'd2);
        u_if1.c_abort = 1'b0;

        // Three words, commit on the third
        for (int i = 0; i < 3; i++) begin
            u_if1.c_data   = 8'hD0 + 8'(i);
            u_if1.c_commit = (i == 2);
            #1;
            check_eq($sformatf("cmt_we%0d", i), 32'(we1), 32'd1);
            tick();
        end
        u_if1.c_commit = 1'b0;
        u_if1.c_srdy   = 1'b0;
        check_eq("cmt_com1", 32'(com1), 32'd5);
        check_eq("cmt_cur1", 32'(cur1), 32'd5);

        // Commit together with abort after 2 writes: abort wins
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check_eq("rst2_cur1", 32'(cur1), 32'd2);
        u_if1.c_srdy = 1'b1;
        tick();
        tick();
        check_eq("ca_pre_cur1", 32'(cur1), 32'd4);
        u_if1.c_commit = 1'b1;
        u_if1.c_abort  = 1'b1;
        #1;
        check_eq("ca_we1", 32'(we1), 32'd0);
        tick();
        u_if1.c_commit = 1'b0;
        u_if1.c_abort  = 1'b0;
        u_if1.c_srdy   = 1'b0;
        check_eq("ca_cur1", 32'(cur1), 32'd2);
        check_eq("ca_com1", 32'(com1), 32'd2);

        // Asynchronous reset mid-packet
        u_if1.c_srdy = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("mid_cur1", 32'(cur1), 32'd7);
        #1;
        reset = 1'b1;
        #1;
        check_eq("arst_cur1", 32'(cur1), 32'd2);
        check_eq("arst_com1", 32'(com1), 32'd2);
        check_eq("arst_we1", 32'(we1), 32'd0);
        check_eq("arst_drdy1", 32'(u_if1.c_drdy), 32'd0);
        tick();
        reset        = 1'b0;
        u_if1.c_srdy = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
